// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  localparam logic [7:0] DEF_RST_PAT = 8'b0000_0110;
  localparam int         DEF_RST_LEN = 3;

  function automatic int calc_len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Zero or oversize lengths fall back to the full pattern width.
  function automatic int clamp_len(input int len, input int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and registered all-ones flag.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && !(&cnt_q))  cnt_d = cnt_q + 1'b1;
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_detector_moore.sv
// Runtime-loadable serial pattern detector with registered match pulse and count.
// Optional SEQDET_POSITION_EN adds a sample index and last_pos output.
module seq_detector_moore
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = calc_len_w(PAT_W),
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int               RST_LEN = DEF_RST_LEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             ovl_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
`ifdef SEQDET_POSITION_EN
  ,
  output logic [15:0]      last_pos
`endif
);

  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, hist_upd, mask;
  logic [LEN_W-1:0] fill_q, fill_d, len_q, len_d, fill_upd;
  logic             match_q, match_d, accept, hit;

  assign accept   = din_valid && !pat_load;
  assign hist_upd = {hist_q[PAT_W-2:0], din};
  assign fill_upd = (fill_q >= len_q) ? len_q : fill_q + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
  end

  // Compare only the newest len bits, and only once len bits have accumulated.
  assign hit = accept && (fill_upd == len_q) && ((hist_upd & mask) == (pat_q & mask));

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    match_d = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      len_d  = LEN_W'(clamp_len(int'(len_in), PAT_W));
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d  = hist_upd;
      fill_d  = (hit && !ovl_en) ? '0 : fill_upd;
      match_d = hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= RST_PAT;
      len_q   <= LEN_W'(RST_LEN);
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hit),
    .clr     (cnt_clr),
    .cnt     (match_cnt),
    .sat     (cnt_sat)
  );

`ifdef SEQDET_POSITION_EN
  logic [15:0] pos_q, pos_d, last_pos_q, last_pos_d;

  // pos_q is the index the current accepted bit receives.
  always_comb begin
    pos_d      = pos_q;
    last_pos_d = last_pos_q;
    if (pat_load) pos_d = '0;
    else if (din_valid) begin
      pos_d = pos_q + 16'd1;
      if (hit) last_pos_d = pos_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q      <= '0;
      last_pos_q <= '0;
    end else begin
      pos_q      <= pos_d;
      last_pos_q <= last_pos_d;
    end
  end

  assign last_pos = last_pos_q;
`endif

endmodule

// File: tb/tb_seq_detector_moore.sv
// Bench for seq_detector_moore: directed scenarios plus random stream against a bit-queue model.
module tb_seq_detector_moore;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             din = 1'b0, din_valid = 1'b0, ovl_en = 1'b1, pat_load = 1'b0, cnt_clr = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic [LEN_W-1:0] len_in = '0;
  logic             match, cnt_sat;
  logic [CNT_W-1:0] match_cnt;

  seq_detector_moore #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .ovl_en(ovl_en),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, hits = 0;
  logic ovl = 1'b1;

  // Model: queue of bits eligible to form a match, newest at the back.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt;
  bit         exp_match;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_0110;
    m_len = 3;
    m_cnt = 0;
    exp_match = 0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit pl, input bit cc,
                            input logic [7:0] pi, input logic [3:0] li, input bit ov);
    bit ok;
    exp_match = 0;
    if (pl) begin
      q.delete();
      m_pat = pi;
      m_len = (li == 0 || li > PAT_W) ? PAT_W : int'(li);
    end else if (v) begin
      q.push_back(d);
      if (q.size() > PAT_W) q.delete(0);
      ok = (q.size() >= m_len);
      if (ok)
        for (int j = 0; j < m_len; j++)
          if (q[q.size() - m_len + j] != m_pat[m_len-1-j]) ok = 0;
      if (ok) begin
        exp_match = 1;
        if (!ov) q.delete();
      end
    end
    if (cc) m_cnt = 0;
    else if (exp_match && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic step(input logic d, input logic v, input logic pl, input logic cc,
                      input logic [7:0] pi, input logic [3:0] li);
    @(negedge clk);
    din = d; din_valid = v; pat_load = pl; cnt_clr = cc; pat_in = pi; len_in = li; ovl_en = ovl;
    @(posedge clk);
    model_step(d, v, pl, cc, pi, li, ovl);
    #1;
    chk("match", int'(match), int'(exp_match));
    chk("match_cnt", int'(match_cnt), m_cnt);
    chk("cnt_sat", int'(cnt_sat), int'(m_cnt == CMAX));
    if (match) hits++;
  endtask

  task automatic bitin(input logic d);
    step(d, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l);
    step(1'b0, 1'b1, 1'b1, 1'b0, p, l);
  endtask

  // Reset asserted between edges; outputs must clear before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    din_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    #1;
    model_reset();
    chk("rst_match", int'(match), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_sat", int'(cnt_sat), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Default pattern 110, overlapping
    ovl = 1'b1; hits = 0;
    bitin(1); bitin(1); bitin(0); bitin(1); bitin(1); bitin(0); idle();
    chk("t1_hits", hits, 2);
    chk("t1_cnt", int'(match_cnt), 2);

    // 1010 len 4, overlap then non-overlap
    do_reset(); ovl = 1'b1; hits = 0;
    load(8'b1010, 4'd4);
    bitin(1); bitin(0); bitin(1); bitin(0); bitin(1); bitin(0); idle();
    chk("t2_ovl_hits", hits, 2);
    do_reset(); ovl = 1'b0; hits = 0;
    load(8'b1010, 4'd4);
    bitin(1); bitin(0); bitin(1); bitin(0); bitin(1); bitin(0); idle();
    chk("t2_novl_hits", hits, 1);

    // Gaps in din_valid
    do_reset(); ovl = 1'b1; hits = 0;
    bitin(1); idle(); idle(); idle(); bitin(1); idle(); idle(); idle(); bitin(0); idle(); idle();
    chk("t3_hits", hits, 1);

    // Load coincident with last pattern bit
    do_reset(); hits = 0;
    bitin(1); bitin(1); load(8'b110, 4'd3);
    chk("t4_hits_after_load", hits, 0);
    bitin(0); bitin(1); bitin(1); bitin(0);
    chk("t4_hits_new", hits, 1);

    // Saturation, then clear together with a hit
    do_reset();
    for (int k = 0; k < 5; k++) begin bitin(1); bitin(1); bitin(0); end
    chk("t5_cnt", int'(match_cnt), 3);
    chk("t5_sat", int'(cnt_sat), 1);
    bitin(1); bitin(1); step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0);
    chk("t5_clr_match", int'(match), 1);
    chk("t5_clr_cnt", int'(match_cnt), 0);

    // Reset mid-pattern reverts the pattern to 110
    do_reset(); hits = 0;
    bitin(1); bitin(1); bitin(0);
    load(8'b1010, 4'd4); bitin(1); bitin(1);
    do_reset(); hits = 0;
    bitin(0); idle();
    chk("t6_no_match", hits, 0);
    bitin(1); bitin(1); bitin(0);
    chk("t6_default_pat", hits, 1);

    // Randomized stream with loads, clears and overlap changes
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [7:0] p;
      logic [3:0] l;
      logic       pl, cc, v, d;
      ovl = ($urandom_range(0, 3) != 0);
      pl  = ($urandom_range(0, 39) == 0);
      cc  = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 4) != 0);
      d   = 1'($urandom_range(0, 1));
      p   = 8'($urandom);
      l   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step(d, v, pl, cc, p, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_moore.md
Name: seq_detector_moore

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 3-bit "110" Moore detector.
- Pattern and pattern length are loadable at runtime. Overlap mode is selectable. Adds an input-valid qualifier and a saturating match counter.
- Sits on a 1-bit serial stream inside the control datapath. Outputs come only from registered state (Moore style).

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W+1), width of the length field.
- CNT_W, 8, match counter width.
- RST_PAT, 8'b0000_0110, pattern after reset (low RST_LEN bits used).
- RST_LEN, 3, pattern length after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din sampled on clk rise only when 1.
- ovl_en  input  1  1 = overlapping detection; 0 = non-overlapping.
- pat_load  input  1  single-cycle strobe; loads pat_in/len_in.
- pat_in  input  PAT_W  new pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- len_in  input  LEN_W  new pattern length.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle detection pulse.
- match_cnt  output  CNT_W  saturating count of detections.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values:
  - history = 0, fill = 0.
  - pat = RST_PAT, len = RST_LEN.
  - match = 0, match_cnt = 0, cnt_sat = 0.
- State:
  - history[PAT_W-1:0] holds the newest bit at the LSB.
  - fill counts valid bits accumulated, saturating at len.
- Sampling, on a clk edge with din_valid=1 and pat_load=0:
  - history <= {history[PAT_W-2:0], din}.
  - fill <= min(fill+1, len).
- Hit condition, evaluated on the updated values: updated fill == len and updated history[len-1:0] == pat[len-1:0].
- On a hit:
  - match is 1 in the cycle after the sampling edge (latency 1 from the last pattern bit), for exactly one cycle.
  - If ovl_en=0, fill is cleared to 0, so the matched bits cannot seed the next match.
  - If ovl_en=1, fill is kept (overlap allowed).
- din_valid=0: history and fill hold; match is 0 next cycle.
- pat_load=1, which has priority over sampling:
  - pat <= pat_in.
  - len <= len_in clamped: 0 or values >PAT_W become PAT_W.
  - history and fill are cleared; the din sample that cycle is discarded; match is 0 next cycle.
- ovl_en is sampled every cycle. A change affects only the next hit.
- match_cnt:
  - +1 on every cycle where match goes high; saturates at 2^CNT_W-1.
  - cnt_clr has priority: a simultaneous hit is not counted and the count becomes 0.
- cnt_sat = (match_cnt == all-ones), registered with match_cnt.
- Reset mid-stream: all state returns to reset values immediately. A partial match is lost, and the pattern reverts to RST_PAT/RST_LEN.

Optional Feature:
- Macro: SEQDET_POSITION_EN.
- Defined:
  - Adds a 16-bit sample index counter that increments per accepted bit, wraps at 0xFFFF, and is cleared by reset and pat_load.
  - Adds output last_pos[15:0]: the index of the final bit of the most recent hit, updated in the same cycle match rises. Reset value 0.
- Undefined: no counter, no port, no logic.

Decomposition:
- Package seq_det_pkg holds:
  - the default RST_PAT/RST_LEN constants;
  - the len clamp function;
  - the LEN_W computation helper.
- One sub-module, sat_counter (parameter W, with inc, clr and sat ports), is instantiated for match_cnt.
- The detector core stays in seq_detector_moore.

Test Plan:
- Reset defaults ("110", len 3), overlap 1, valid stream 1,1,0,1,1,0 -> match pulses 1 cycle after the 3rd and 6th bits; match_cnt = 2.
- Load pat 4'b1010, len 4, stream 1,0,1,0,1,0: ovl_en=1 -> 2 matches; ovl_en=0 -> 1 match.
- Stream 1,1,0 with din_valid low for 3 cycles between the bits -> exactly one match pulse, after the final valid 0.
- pat_load asserted together with the last pattern bit -> no match; fill = 0; the next bits are evaluated against the new pattern.
- CNT_W=2, 5 hits -> match_cnt saturates at 3 with cnt_sat=1. Then cnt_clr together with a hit -> match_cnt = 0.
- reset_n pulsed low mid-pattern (after 1,1) -> outputs reset asynchronously. A following 0 gives no match; the pattern returns to "110".
